// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame decoder: FSM states,
// error codes reported on err_code, and the default frame sync marker.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHECK
  } state_e;

  localparam logic [1:0] ERR_LEN  = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_LINK = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/uart_word_shift.sv
// Little-endian byte-to-word assembler: places each byte at the current
// byte slot and flags the byte that completes a word.
module uart_word_shift #(
  parameter int WORD_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    shift_i,
  input  logic [7:0]              byte_i,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic                    complete_o
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [IW-1:0] byteIdx_q, byteIdx_d;
  logic [W-1:0]  asm_q, asm_d;

  // word_o includes the incoming byte so the holding register can be
  // loaded on the same edge that consumes the final byte of a word.
  always_comb begin
    asm_d = asm_q;
    asm_d[{byteIdx_q, 3'b000} +: 8] = byte_i;
    word_o     = asm_d;
    complete_o = shift_i && (byteIdx_q == IW'(WORD_BYTES - 1));
    byteIdx_d  = byteIdx_q;
    if (clear_i) begin
      byteIdx_d = '0;
    end else if (shift_i) begin
      byteIdx_d = complete_o ? '0 : byteIdx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byteIdx_q <= '0;
      asm_q     <= '0;
    end else begin
      byteIdx_q <= byteIdx_d;
      if (shift_i && !clear_i) begin
        asm_q <= asm_d;
      end
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Frame decoder behind the UART receiver: finds SYNC/LEN/payload/CHK frames,
// streams payload words on valid/ready and reports frame status and errors.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         WORD_BYTES     = 2,
  parameter int         MAX_WORDS      = 16,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC,
  parameter int         TIMEOUT_CYCLES = 125000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  input  logic                    link_error,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    word_last,
  output logic                    frame_done,
  output logic                    frame_error,
  output logic [1:0]              err_code,
  output logic                    busy
);

  localparam int         W    = 8 * WORD_BYTES;
  localparam int         TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAXW = 8'(MAX_WORDS);

  state_e        state_q, state_d;
  logic [7:0]    wordCnt_q, wordCnt_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [W-1:0]  wordData_q, wordData_d;
  logic          wordValid_q, wordValid_d;
  logic          wordLast_q, wordLast_d;
  logic          frameDone_q, frameDone_d;
  logic          frameError_q, frameError_d;
  logic [1:0]    errCode_q, errCode_d;

  logic          byteEv;
  logic          shiftEn;
  logic          wordDone;
  logic [W-1:0]  asmWord;
  logic          errHit;
  logic [1:0]    errSel;

  // A link error in the same cycle as a byte strobe drops that byte.
  assign byteEv  = byte_valid && !link_error;
  assign shiftEn = byteEv && (state_q == PAYLOAD);

  uart_word_shift #(
    .WORD_BYTES(WORD_BYTES)
  ) uShift (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q != PAYLOAD),
    .shift_i   (shiftEn),
    .byte_i    (byte_data),
    .word_o    (asmWord),
    .complete_o(wordDone)
  );

  always_comb begin
    state_d      = state_q;
    wordCnt_d    = wordCnt_q;
    chk_d        = chk_q;
    wordData_d   = wordData_q;
    wordValid_d  = wordValid_q;
    wordLast_d   = wordLast_q;
    frameDone_d  = 1'b0;
    frameError_d = 1'b0;
    errCode_d    = errCode_q;
    errHit       = 1'b0;
    errSel       = ERR_LEN;
    tmo_d        = (state_q == IDLE || byte_valid) ? '0 : tmo_q + 1'b1;

    if (wordValid_q && word_ready) begin
      wordValid_d = 1'b0;
      wordLast_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (byteEv && byte_data == SYNC_BYTE) state_d = LEN;
      end
      LEN: begin
        if (byteEv) begin
          if (byte_data == 8'd0 || byte_data > MAXW) begin
            errHit = 1'b1;
            errSel = ERR_LEN;
          end else begin
            wordCnt_d = byte_data;
            chk_d     = byte_data;
            state_d   = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byteEv) begin
          chk_d = chk_q ^ byte_data;
          // Completion is only safe if the slot is empty or drains this cycle.
          if (wordDone) begin
            if (wordValid_q && !word_ready) begin
              errHit = 1'b1;
              errSel = ERR_OVF;
            end else begin
              wordData_d  = asmWord;
              wordValid_d = 1'b1;
              wordLast_d  = (wordCnt_q == 8'd1);
              wordCnt_d   = wordCnt_q - 8'd1;
              if (wordCnt_q == 8'd1) state_d = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (byteEv) begin
          if (byte_data == chk_q) begin
            frameDone_d = 1'b1;
            state_d     = IDLE;
          end else begin
            errHit = 1'b1;
            errSel = ERR_CHK;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE &&
        (link_error || (!byte_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1)))) begin
      errHit = 1'b1;
      errSel = ERR_LINK;
    end

    if (errHit) begin
      state_d      = IDLE;
      frameError_d = 1'b1;
      errCode_d    = errSel;
      wordValid_d  = 1'b0;
      wordLast_d   = 1'b0;
      frameDone_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wordCnt_q    <= '0;
      chk_q        <= '0;
      tmo_q        <= '0;
      wordData_q   <= '0;
      wordValid_q  <= 1'b0;
      wordLast_q   <= 1'b0;
      frameDone_q  <= 1'b0;
      frameError_q <= 1'b0;
      errCode_q    <= '0;
    end else begin
      state_q      <= state_d;
      wordCnt_q    <= wordCnt_d;
      chk_q        <= chk_d;
      tmo_q        <= tmo_d;
      wordData_q   <= wordData_d;
      wordValid_q  <= wordValid_d;
      wordLast_q   <= wordLast_d;
      frameDone_q  <= frameDone_d;
      frameError_q <= frameError_d;
      errCode_q    <= errCode_d;
    end
  end

  assign word_data   = wordData_q;
  assign word_valid  = wordValid_q;
  assign word_last   = wordLast_q;
  assign frame_done  = frameDone_q;
  assign frame_error = frameError_q;
  assign err_code    = errCode_q;
  assign busy        = (state_q != IDLE);

endmodule
